// File: rtl/alu_top.sv
// alu_top: registered MIPS-style EX-stage ALU with built-in ALU-control decode.
// The 6-bit opcode (and, for R-type, the 6-bit function field) is decoded into
// an internal 4-bit operation; the 32-bit result and its zero flag are
// registered on the rising clock edge.
//
// Optional feature: define ALU_VSHIFT_EN to add the R-type variable shifts
// sllv / srlv / srav. Without it those function codes decode as undefined and
// no shifter is built.
module alu_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_field,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        zero
);

    // Internal ALU operation produced by the control decode. OP_NONE covers
    // every undefined opcode/function combination and forces a zero result.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLLV = 4'd8,
        OP_SRLV = 4'd9,
        OP_SRAV = 4'd10,
        OP_NONE = 4'd15
    } aluOp_e;

    // Primary opcodes recognised by the decode.
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes.
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    aluOp_e      aluOp;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        zero_d;
    logic        zero_q;
    logic        sltSigned;
    logic        sltUnsigned;

    // Control decode: R-type instructions are steered by the function field,
    // everything else by the opcode alone; loads, stores and branches reuse
    // the add/subtract paths since they only need an address or a difference.
    always_comb begin
        aluOp = OP_NONE;
        if (opcode == OPC_RTYPE) begin
            unique case (func_field)
                FN_ADD, FN_ADDU: aluOp = OP_ADD;
                FN_SUB, FN_SUBU: aluOp = OP_SUB;
                FN_AND:          aluOp = OP_AND;
                FN_OR:           aluOp = OP_OR;
                FN_XOR:          aluOp = OP_XOR;
                FN_NOR:          aluOp = OP_NOR;
                FN_SLT:          aluOp = OP_SLT;
                FN_SLTU:         aluOp = OP_SLTU;
`ifdef ALU_VSHIFT_EN
                FN_SLLV:         aluOp = OP_SLLV;
                FN_SRLV:         aluOp = OP_SRLV;
                FN_SRAV:         aluOp = OP_SRAV;
`endif
                default:         aluOp = OP_NONE;
            endcase
        end else begin
            unique case (opcode)
                OPC_LW, OPC_SW:       aluOp = OP_ADD;
                OPC_ADDI, OPC_ADDIU:  aluOp = OP_ADD;
                OPC_BEQ, OPC_BNE:     aluOp = OP_SUB;
                OPC_ANDI:             aluOp = OP_AND;
                OPC_ORI:              aluOp = OP_OR;
                OPC_XORI:             aluOp = OP_XOR;
                OPC_SLTI:             aluOp = OP_SLT;
                OPC_SLTIU:            aluOp = OP_SLTU;
                default:              aluOp = OP_NONE;
            endcase
        end
    end

    // Signed and unsigned less-than flags shared by the register and
    // immediate forms of set-on-less-than.
    always_comb begin
        sltSigned   = ($signed(A) < $signed(B));
        sltUnsigned = (A < B);
    end

    // Datapath: compute the next result for the decoded operation and derive
    // the zero flag from that same value so the two registers always agree.
    always_comb begin
        result_d = 32'h0;
        unique case (aluOp)
            OP_ADD:  result_d = A + B;
            OP_SUB:  result_d = A - B;
            OP_AND:  result_d = A & B;
            OP_OR:   result_d = A | B;
            OP_XOR:  result_d = A ^ B;
            OP_NOR:  result_d = ~(A | B);
            OP_SLT:  result_d = {31'b0, sltSigned};
            OP_SLTU: result_d = {31'b0, sltUnsigned};
`ifdef ALU_VSHIFT_EN
            OP_SLLV: result_d = B << A[4:0];
            OP_SRLV: result_d = B >> A[4:0];
            OP_SRAV: result_d = $signed(B) >>> A[4:0];
`endif
            default: result_d = 32'h0;
        endcase
        zero_d = (result_d == 32'h0);
    end

    // Output registers; reset clears the result, which makes zero read 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 32'h0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: self-checking bench for alu_top. Directed scenarios from the
// block's behaviour plus randomized operations checked against a behavioural
// reference model. Honours ALU_VSHIFT_EN the same way the design does.
module tb_alu_top;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  func_field;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        zero;

    int checks;
    int failures;

    alu_top dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .func_field (func_field),
        .A          (A),
        .B          (B),
        .result     (result),
        .zero       (zero)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: what the instruction means, in plain arithmetic.
    function automatic logic [31:0] refModel(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, pw;
        logic [31:0] r;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
        sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
        pw = longint'(1) << a[4:0];
        r  = 32'h0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: r = 32'((ua + ub) % 64'sd4294967296);
                6'h22, 6'h23: r = 32'((ua - ub + 64'sd4294967296) % 64'sd4294967296);
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = 32'hFFFFFFFF - (a | b);
                6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: r = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_VSHIFT_EN
                6'h04: r = 32'((ub * pw) % 64'sd4294967296);
                6'h06: r = 32'(ub / pw);
                6'h07: r = (sb >= 0) ? 32'(sb / pw)
                                     : 32'(((sb - (pw - 1)) / pw) + 64'sd4294967296);
`endif
                default: r = 32'h0;
            endcase
        end else begin
            case (op)
                6'h23, 6'h2B, 6'h08, 6'h09: r = 32'((ua + ub) % 64'sd4294967296);
                6'h04, 6'h05: r = 32'((ua - ub + 64'sd4294967296) % 64'sd4294967296);
                6'h0C: r = a & b;
                6'h0D: r = a | b;
                6'h0E: r = a ^ b;
                6'h0A: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h0B: r = (ua < ub) ? 32'd1 : 32'd0;
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    // Drive one operation at the falling edge, then wait until just after the
    // next rising edge so the registered outputs can be sampled.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opcode     = op;
        func_field = fn;
        A          = a;
        B          = b;
        @(posedge clk);
        #1;
    endtask

    // Reset clears outputs immediately and holds them while a non-zero add is pending.
    task automatic test_reset();
        rst_n = 1'b1;
        applyStimulus(6'h00, 6'h20, 32'h2222, 32'h1111);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_async result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_hold result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({zero, result} !== {1'b0, 32'h3333}) begin
            failures++;
            $display("[TB] FAIL reset_release result=%h zero=%b expected result=00003333 zero=0", result, zero);
        end
    endtask

    // Logic operations with the reference operands.
    task automatic test_logic();
        applyStimulus(6'h00, 6'h24, 32'h2222, 32'h1111);
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL and result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        applyStimulus(6'h00, 6'h25, 32'h2222, 32'h1111);
        checks++;
        if ({zero, result} !== {1'b0, 32'h3333}) begin
            failures++;
            $display("[TB] FAIL or result=%h zero=%b expected result=00003333 zero=0", result, zero);
        end
        applyStimulus(6'h00, 6'h27, 32'h2222, 32'h1111);
        checks++;
        if ({zero, result} !== {1'b0, 32'hFFFFCCCC}) begin
            failures++;
            $display("[TB] FAIL nor result=%h zero=%b expected result=ffffcccc zero=0", result, zero);
        end
        applyStimulus(6'h00, 6'h22, 32'h1111, 32'h2222);
        checks++;
        if ({zero, result} !== {1'b0, 32'hFFFFEEEF}) begin
            failures++;
            $display("[TB] FAIL sub result=%h zero=%b expected result=ffffeeef zero=0", result, zero);
        end
    endtask

    // I-type address generation and branch compare.
    task automatic test_itype();
        applyStimulus(6'h23, 6'h00, 32'h2222, 32'h1111);
        checks++;
        if ({zero, result} !== {1'b0, 32'h3333}) begin
            failures++;
            $display("[TB] FAIL lw result=%h zero=%b expected result=00003333 zero=0", result, zero);
        end
        applyStimulus(6'h04, 6'h2A, 32'h5555, 32'h5555);
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL beq result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        applyStimulus(6'h0E, 6'h00, 32'hF0F0F0F0, 32'h0000FFFF);
        checks++;
        if ({zero, result} !== {1'b0, 32'hF0F00F0F}) begin
            failures++;
            $display("[TB] FAIL xori result=%h zero=%b expected result=f0f00f0f zero=0", result, zero);
        end
    endtask

    // Signed versus unsigned set-on-less-than.
    task automatic test_compare();
        applyStimulus(6'h00, 6'h2A, 32'h1111, 32'h2222);
        checks++;
        if ({zero, result} !== {1'b0, 32'h1}) begin
            failures++;
            $display("[TB] FAIL slt_pos result=%h zero=%b expected result=00000001 zero=0", result, zero);
        end
        applyStimulus(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1);
        checks++;
        if ({zero, result} !== {1'b0, 32'h1}) begin
            failures++;
            $display("[TB] FAIL slt_neg result=%h zero=%b expected result=00000001 zero=0", result, zero);
        end
        applyStimulus(6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1);
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL sltu result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        applyStimulus(6'h0A, 6'h00, 32'h80000000, 32'h7FFFFFFF);
        checks++;
        if ({zero, result} !== {1'b0, 32'h1}) begin
            failures++;
            $display("[TB] FAIL slti result=%h zero=%b expected result=00000001 zero=0", result, zero);
        end
    endtask

    // Wraparound, undefined encodings and mid-cycle input changes.
    task automatic test_boundary();
        applyStimulus(6'h00, 6'h20, 32'hFFFFFFFF, 32'h1);
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL add_wrap result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        applyStimulus(6'h00, 6'h20, 32'h2222, 32'h1111);
        applyStimulus(6'h3F, 6'h20, 32'h2222, 32'h1111);
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL undef_opcode result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        applyStimulus(6'h00, 6'h3F, 32'h2222, 32'h1111);
        checks++;
        if ({zero, result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL undef_func result=%h zero=%b expected result=00000000 zero=1", result, zero);
        end
        applyStimulus(6'h00, 6'h21, 32'h2222, 32'h1111);
        #2;
        A          = 32'h1;
        B          = 32'h2;
        func_field = 6'h26;
        #2;
        checks++;
        if ({zero, result} !== {1'b0, 32'h3333}) begin
            failures++;
            $display("[TB] FAIL midcycle_hold result=%h zero=%b expected result=00003333 zero=0", result, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({zero, result} !== {1'b0, 32'h3}) begin
            failures++;
            $display("[TB] FAIL midcycle_update result=%h zero=%b expected result=00000003 zero=0", result, zero);
        end
    endtask

    // Variable shifts: real values with the feature, zero without it.
    task automatic test_vshift();
        logic [31:0] expSra;
        logic [31:0] expSll;
`ifdef ALU_VSHIFT_EN
        expSra = 32'hF8000000;
        expSll = 32'h80000000;
`else
        expSra = 32'h0;
        expSll = 32'h0;
`endif
        applyStimulus(6'h00, 6'h07, 32'd4, 32'h80000000);
        checks++;
        if ({zero, result} !== {(expSra == 32'h0), expSra}) begin
            failures++;
            $display("[TB] FAIL srav result=%h zero=%b expected result=%h zero=%b", result, zero, expSra, expSra == 32'h0);
        end
        applyStimulus(6'h00, 6'h04, 32'd31, 32'h1);
        checks++;
        if ({zero, result} !== {(expSll == 32'h0), expSll}) begin
            failures++;
            $display("[TB] FAIL sllv result=%h zero=%b expected result=%h zero=%b", result, zero, expSll, expSll == 32'h0);
        end
    endtask

    // Randomized back-to-back operations against the reference model.
    task automatic test_random();
        logic [5:0]  opTab [13];
        logic [5:0]  fnTab [16];
        logic [5:0]  op, fn;
        logic [31:0] a, b, exp;
        opTab = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D,
                  6'h0E, 6'h0A, 6'h0B, 6'h00, 6'h00};
        fnTab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                  6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h2A, 6'h2B, 6'h22};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = opTab[$urandom_range(12)];
                fn = fnTab[$urandom_range(15)];
            end
            case ($urandom_range(3))
                0:       a = $urandom_range(15);
                1:       a = 32'h80000000 | $urandom;
                default: a = $urandom;
            endcase
            b = ($urandom_range(7) == 0) ? a : $urandom;
            exp = refModel(op, fn, a, b);
            applyStimulus(op, fn, a, b);
            checks++;
            if ({zero, result} !== {(exp == 32'h0), exp}) begin
                failures++;
                $display("[TB] FAIL random op=%h fn=%h a=%h b=%h result=%h zero=%b expected result=%h zero=%b",
                         op, fn, a, b, result, zero, exp, exp == 32'h0);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        opcode     = 6'h00;
        func_field = 6'h20;
        A          = 32'h0;
        B          = 32'h0;
        #12;
        test_reset();
        test_logic();
        test_itype();
        test_compare();
        test_boundary();
        test_vshift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
